// File: rtl/airhockey_pkg.sv
// airhockey_pkg: shared types and constants for the air-hockey scoreboard.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package airhockey_pkg;

    // Match sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HOLD = 2'd2,
        ST_OVER = 2'd3
    } match_state_e;

    // Encoding of the winner output.
    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

    // BCD digits: ones run 0..9, tens only reach 7 because a match ends at 79 or below.
    typedef logic [3:0] bcd_ones_t;
    typedef logic [2:0] bcd_tens_t;

    // Split a binary constant (0..79) into BCD digits at elaboration time.
    function automatic bcd_ones_t bcd_ones_of(input int unsigned v);
        return bcd_ones_t'(v % 10);
    endfunction

    function automatic bcd_tens_t bcd_tens_of(input int unsigned v);
        return bcd_tens_t'(v / 10);
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: one player's two-digit BCD score with clear, increment and win detect.
// Latency: clear/increment visible on the digit outputs 1 cycle later; win flag is combinational.
// Backpressure: none; inc is applied in the cycle it is high.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clr             synchronous clear to 00 (wins over inc)
//   inc             add one to the score
//   ones, tens      registered BCD digits
//   inc_hits_win    the score after one increment equals WIN_SCORE
module bcd_score_counter
    import airhockey_pkg::*;
#(
    parameter int unsigned WIN_SCORE = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] ones,
    output logic [2:0] tens,
    output logic       inc_hits_win
);

    localparam bcd_ones_t WIN_ONES = bcd_ones_of(WIN_SCORE);
    localparam bcd_tens_t WIN_TENS = bcd_tens_of(WIN_SCORE);

    bcd_ones_t ones_q, ones_d, ones_inc;
    bcd_tens_t tens_q, tens_d, tens_inc;

    // Value the score would take after one increment.
    always_comb begin
        ones_inc = ones_q + 4'd1;
        tens_inc = tens_q;
        if (ones_q == 4'd9) begin
            ones_inc = 4'd0;
            tens_inc = tens_q + 3'd1;
        end
    end

    // The FSM needs to know before the edge whether this goal ends the match,
    // so the comparison is made on the incremented value, not the stored one.
    assign inc_hits_win = (ones_inc == WIN_ONES) && (tens_inc == WIN_TENS);

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (clr) begin
            ones_d = '0;
            tens_d = '0;
        end else if (inc) begin
            ones_d = ones_inc;
            tens_d = tens_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q <= '0;
            tens_q <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign ones = ones_q;
    assign tens = tens_q;

endmodule

// File: rtl/score_controller.sv
// score_controller: air-hockey match sequencer -- BCD scores, match FSM, display refresh and winner blink.
// Latency: goal/start pulse to registered score/status outputs is 1 cycle.
// Backpressure: none; goal and start pulses are consumed or ignored in the cycle they arrive.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start                       begin/restart a match (any state)
//   p1_goal, p2_goal            one-cycle goal pulses
//   p1_ones/p1_tens/p2_*        BCD score digits
//   refresh_tick                one-cycle display scan enable every REFRESH_DIV clocks
//   puck_release                one-cycle pulse on every entry into PLAY
//   game_over, winner           match result (winner: 00 none, 01 P1, 10 P2)
//   blank_p1, blank_p2          blank that player's digits
// Optional build macro SCORE_BLINK_EN: blink the winner's digits in OVER every
// BLINK_DIV refresh ticks; without it the blank outputs are tied low.
module score_controller
    import airhockey_pkg::*;
#(
    parameter int unsigned WIN_SCORE        = 7,
    parameter int unsigned REFRESH_DIV      = 100000,
    parameter int unsigned GOAL_HOLD_CYCLES = 50000000,
    parameter int unsigned BLINK_DIV        = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       p1_goal,
    input  logic       p2_goal,
    output logic [3:0] p1_ones,
    output logic [2:0] p1_tens,
    output logic [3:0] p2_ones,
    output logic [2:0] p2_tens,
    output logic       refresh_tick,
    output logic       puck_release,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       blank_p1,
    output logic       blank_p2
);

    localparam int unsigned HOLD_W = $clog2(GOAL_HOLD_CYCLES + 1);
    localparam int unsigned REF_W  = $clog2(REFRESH_DIV + 1);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(GOAL_HOLD_CYCLES - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);

    // ------------------------------------------------------------------
    // Per-player score counters
    // ------------------------------------------------------------------
    logic score_clr;
    logic p1_inc, p2_inc;
    logic p1_hits_win, p2_hits_win;

    bcd_score_counter #(.WIN_SCORE(WIN_SCORE)) u_p1_score (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (score_clr),
        .inc          (p1_inc),
        .ones         (p1_ones),
        .tens         (p1_tens),
        .inc_hits_win (p1_hits_win)
    );

    bcd_score_counter #(.WIN_SCORE(WIN_SCORE)) u_p2_score (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (score_clr),
        .inc          (p2_inc),
        .ones         (p2_ones),
        .tens         (p2_tens),
        .inc_hits_win (p2_hits_win)
    );

    // ------------------------------------------------------------------
    // Match FSM
    // ------------------------------------------------------------------
    match_state_e      state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              release_q, release_d;
    logic              game_over_q, game_over_d;
    logic [1:0]        winner_q, winner_d;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        release_d = 1'b0;
        winner_d  = winner_q;
        score_clr = 1'b0;
        p1_inc    = 1'b0;
        p2_inc    = 1'b0;

        if (start) begin
            // Restart from any state; outranks a goal in the same cycle.
            state_d   = ST_PLAY;
            hold_d    = '0;
            release_d = 1'b1;
            winner_d  = WINNER_NONE;
            score_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_PLAY: begin
                    // Simultaneous goals cancel out: nobody scores, play continues.
                    if (p1_goal ^ p2_goal) begin
                        p1_inc = p1_goal;
                        p2_inc = p2_goal;
                        if ((p1_goal && p1_hits_win) || (p2_goal && p2_hits_win)) begin
                            state_d  = ST_OVER;
                            winner_d = p1_goal ? WINNER_P1 : WINNER_P2;
                        end else begin
                            // Loaded with N-1 and left at 0 gives exactly N cycles in HOLD.
                            state_d = ST_HOLD;
                            hold_d  = HOLD_LOAD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_q == '0) begin
                        state_d   = ST_PLAY;
                        release_d = 1'b1;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                ST_OVER: ;
                default: state_d = ST_IDLE;
            endcase
        end

        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            release_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= WINNER_NONE;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            release_q   <= release_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign puck_release = release_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;

    // ------------------------------------------------------------------
    // Display refresh divider (free-running, independent of match state)
    // ------------------------------------------------------------------
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic             ref_tick_q, ref_tick_d;

    always_comb begin
        ref_tick_d = (ref_cnt_q == REF_LAST);
        ref_cnt_d  = ref_tick_d ? '0 : ref_cnt_q + REF_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q  <= '0;
            ref_tick_q <= 1'b0;
        end else begin
            ref_cnt_q  <= ref_cnt_d;
            ref_tick_q <= ref_tick_d;
        end
    end

    assign refresh_tick = ref_tick_q;

    // ------------------------------------------------------------------
    // Winner blink
    // ------------------------------------------------------------------
`ifdef SCORE_BLINK_EN
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_ph_q, blink_ph_d;

    // Held cleared outside OVER so every win starts with the digits visible.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (state_q != ST_OVER) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (ref_tick_q) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    assign blank_p1 = game_over_q && (winner_q == WINNER_P1) && blink_ph_q;
    assign blank_p2 = game_over_q && (winner_q == WINNER_P2) && blink_ph_q;
`else
    // Keeps the blink divider parameter referenced in builds without blinking.
    logic blink_div_unused;
    assign blink_div_unused = (BLINK_DIV != 0);

    assign blank_p1 = 1'b0;
    assign blank_p2 = 1'b0;
`endif

endmodule

// File: doc/score_controller.md
# score_controller

Match sequencer for the air-hockey scoreboard. Accepts per-player goal pulses, keeps both scores as BCD digits, runs the match state machine (idle, play, post-goal hold, game over), and drives the four-digit multiplexed score display with its digit values, a refresh-enable tick and winner-blink blanking. Sits between the puck/goal detection logic and the seven-segment display driver.

## Interface
- `WIN_SCORE`, default 7: score that ends the match; legal range 1..79.
- `REFRESH_DIV`, default 100000: clocks per `refresh_tick` pulse, which advances the display digit scan.
- `GOAL_HOLD_CYCLES`, default 50000000: length of the post-goal pause in clocks; minimum 1.
- `BLINK_DIV`, default 250: `refresh_tick` pulses per blink half-period.
- `clk` in 1: the single clock; all logic runs on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle pulse; begins or restarts a match.
- `p1_goal`, `p2_goal` in 1 each: one-cycle goal pulses, synchronous to `clk`.
- `p1_ones`, `p2_ones` out 4 each: BCD ones digits, range 0..9.
- `p1_tens`, `p2_tens` out 3 each: BCD tens digits, range 0..7.
- `refresh_tick` out 1: one-cycle display scan enable.
- `puck_release` out 1: one-cycle pulse when play (re)starts.
- `game_over` out 1: high while in the OVER state.
- `winner` out 2: 00 = none, 01 = P1, 10 = P2.
- `blank_p1`, `blank_p2` out 1 each: when high, the display blanks that player's two digits.

## Operation
- FSM states:
  - IDLE, entered from reset. Goals are ignored. `start` clears both scores, pulses `puck_release` and moves to PLAY.
  - PLAY. A goal from exactly one player increments that player's BCD score.
    - New score equals `WIN_SCORE`: go to OVER and set `winner`.
    - Otherwise go to HOLD and load the hold timer with `GOAL_HOLD_CYCLES`-1.
  - Both goals in the same cycle: neither counts, and the FSM stays in PLAY.
  - HOLD. Goals are ignored. The timer decrements each cycle; at 0 the FSM pulses `puck_release` and moves to PLAY.
  - OVER. Goals are ignored, and scores and `winner` hold. `start` clears everything, pulses `puck_release` and moves to PLAY.
- `start` in PLAY or HOLD restarts the match. It has the same effect as in OVER and takes priority over a goal in the same cycle.
- BCD increment: ones 0..8 become ones+1. Ones 9 becomes ones 0 with tens+1. Tens never exceeds 7, because `WIN_SCORE` ≤ 79 stops the match first.
- Refresh counter: free-running from 0 to `REFRESH_DIV`-1. `refresh_tick` is high for the one cycle after the counter wraps. It is independent of FSM state.

## Timing
- Reset values: all score digits 0, `refresh_tick` 0, `puck_release` 0, `game_over` 0, `winner` 00, `blank_p1` 0, `blank_p2` 0. FSM is in IDLE and all counters are 0.
- Score outputs are registered and change on the first edge after the goal pulse (1-cycle latency).
- `game_over` and `winner` update on the same edge as the winning score.
- `puck_release` is asserted on the same edge as the entry into PLAY.
- HOLD lasts exactly `GOAL_HOLD_CYCLES` cycles, counted from the edge that entered it.
- Reset mid-match: immediate return to reset values, with no `puck_release`.

## Configuration
- `SCORE_BLINK_EN` defined:
  - In OVER, the winner's `blank_pX` toggles every `BLINK_DIV` `refresh_tick` pulses, starting low on entry to OVER.
  - The loser's blank output stays 0.
  - Both blank outputs are 0 in all other states.
- `SCORE_BLINK_EN` undefined: `blank_p1`/`blank_p2` are tied to 0, and the blink counter is not built.

## Structure
- Shared package `airhockey_pkg` holds:
  - the FSM state enum (IDLE/PLAY/HOLD/OVER);
  - the `winner` encoding constants;
  - the BCD digit typedefs (4-bit ones, 3-bit tens).
- Sub-module `bcd_score_counter`, instantiated once per player. It has a synchronous clear, an increment enable, ones/tens outputs, and a flag for equality with `WIN_SCORE`.

## Test plan
Bench overrides: `REFRESH_DIV`=4, `GOAL_HOLD_CYCLES`=8, `BLINK_DIV`=2.
- Reset, then `p1_goal` pulses before `start` -> all digits stay 0 and `game_over`=0.
- `start`, then `p1_goal` -> `puck_release` on the `start` edge, `p1_ones`=1 the next cycle. A `p2_goal` during HOLD is ignored. `puck_release` pulses exactly 8 cycles after HOLD entry.
- `WIN_SCORE`=15, ten `p2_goal`s each separated by HOLD -> `p2_tens`=1, `p2_ones`=0, FSM back in PLAY.
- `WIN_SCORE`=7, P1 scores 7 -> `game_over`=1, `winner`=01. Further goals are ignored. `start` clears the scores and sets `winner`=00.
- `p1_goal` and `p2_goal` in the same cycle during PLAY -> scores unchanged, FSM stays in PLAY.
- `refresh_tick` after reset -> pulses every 4 cycles. With `SCORE_BLINK_EN`, after a P2 win `blank_p2` toggles every 8 cycles and `blank_p1` stays 0.
